multicycle_control: RTL and testbench

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

---
 rtl/multicycle_control_pkg.sv | 55 +++++
 rtl/multicycle_control_mem_wait_timer.sv | 29 ++
 rtl/multicycle_control.sv | 184 ++++++++++++++++++
 tb/tb_multicycle_control.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/multicycle_control_pkg.sv
// multicycle_control_pkg: shared encodings for the multicycle controller.
// UPPER_IMM_EN adds LUI/AUIPC to the legal opcode set.
package multicycle_control_pkg;

    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_MEM    = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;
    localparam logic [2:0] S_TRAP   = 3'd5;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam int WAIT_W = 8;

    typedef enum logic [1:0] {ALU_ADD, ALU_BR, ALU_R, ALU_I} alu_op_e;
    typedef enum logic [1:0] {PC_ALU, PC_ALUOUT} pc_src_e;
    typedef enum logic [1:0] {A_PC, A_RS1, A_ZERO} src_a_e;
    typedef enum logic [1:0] {B_RS2, B_FOUR, B_IMM} src_b_e;
    typedef enum logic [1:0] {M2R_ALUOUT, M2R_MDR, M2R_PC} m2r_e;

    typedef struct packed {
        logic    mem_read;
        logic    mem_write;
        logic    i_or_d;
        logic    ir_write;
        logic    pc_write;
        logic    pc_write_cond;
        pc_src_e pc_source;
        src_a_e  alu_src_a;
        src_b_e  alu_src_b;
        alu_op_e alu_op;
        m2r_e    mem_to_reg;
        logic    reg_write;
    } ctrl_t;

    function automatic logic is_legal(input logic [6:0] op);
        logic base;
        base = op inside {OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR};
`ifdef UPPER_IMM_EN
        return base || (op inside {OP_LUI, OP_AUIPC});
`else
        return base;
`endif
    endfunction

endpackage

// File: rtl/multicycle_control_mem_wait_timer.sv
// mem_wait_timer: counts wait cycles of one memory access and flags the timeout.
module mem_wait_timer
    import multicycle_control_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic active,
    input  logic mem_ready,
    output logic timeout
);

    logic [WAIT_W-1:0] cnt;
    logic              at_limit;

    assign at_limit = cnt == WAIT_W'(MEM_TIMEOUT);
    // a ready access at the limit still completes; only a further stall traps
    assign timeout  = active && !mem_ready && at_limit;

    always_ff @(posedge clk) begin
        if (reset || clear)
            cnt <= '0;
        else if (active && !mem_ready && !at_limit)
            cnt <= cnt + WAIT_W'(1);
    end

endmodule

// File: rtl/multicycle_control.sv
// multicycle_control: FSM controller for a multicycle RV32 datapath with traps and retire count.
// UPPER_IMM_EN makes LUI/AUIPC legal; otherwise they trap as illegal.
module multicycle_control
    import multicycle_control_pkg::*;
#(
    parameter int ALU_OP_W    = 2,
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [6:0]          opcode,
    input  logic                mem_ready,
    output logic                mem_read,
    output logic                mem_write,
    output logic                i_or_d,
    output logic                ir_write,
    output logic                pc_write,
    output logic                pc_write_cond,
    output logic [1:0]          pc_source,
    output logic [1:0]          alu_src_a,
    output logic [1:0]          alu_src_b,
    output logic [ALU_OP_W-1:0] alu_op,
    output logic [1:0]          mem_to_reg,
    output logic                reg_write,
    output logic [2:0]          state,
    output logic                illegal,
    output logic                bus_error,
    output logic [CNT_W-1:0]    retired
);

    ctrl_t      c;
    logic [2:0] next;
    logic       retire, set_illegal, set_bus_error;
    logic       timeout, is_load, timer_clear, timer_active;

    assign is_load      = opcode == OP_LOAD;
    assign timer_active = state == S_FETCH || state == S_MEM;
    assign timer_clear  = next != state && (next == S_FETCH || next == S_MEM);

    mem_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timer (
        .clk      (clk),
        .reset    (reset),
        .clear    (timer_clear),
        .active   (timer_active),
        .mem_ready(mem_ready),
        .timeout  (timeout)
    );

    always_comb begin
        c             = '0;
        next          = state;
        retire        = 1'b0;
        set_illegal   = 1'b0;
        set_bus_error = 1'b0;
        case (state)
            S_FETCH: begin
                c.mem_read  = 1'b1;
                c.alu_src_b = B_FOUR;
                if (mem_ready) begin
                    c.ir_write = 1'b1;
                    c.pc_write = 1'b1;
                    next       = S_DECODE;
                end else if (timeout) begin
                    next          = S_TRAP;
                    set_bus_error = 1'b1;
                end
            end
            S_DECODE: begin
                c.alu_src_b = B_IMM;
                next        = is_legal(opcode) ? S_EXEC : S_TRAP;
                set_illegal = !is_legal(opcode);
            end
            S_EXEC: begin
                case (opcode)
                    OP_R: begin
                        c.alu_src_a = A_RS1;
                        c.alu_op    = ALU_R;
                        next        = S_WB;
                    end
                    OP_I: begin
                        c.alu_src_a = A_RS1;
                        c.alu_src_b = B_IMM;
                        c.alu_op    = ALU_I;
                        next        = S_WB;
                    end
                    OP_LOAD, OP_STORE: begin
                        c.alu_src_a = A_RS1;
                        c.alu_src_b = B_IMM;
                        next        = S_MEM;
                    end
                    OP_BRANCH: begin
                        c.alu_src_a     = A_RS1;
                        c.alu_op        = ALU_BR;
                        c.pc_write_cond = 1'b1;
                        c.pc_source     = PC_ALUOUT;
                        next            = S_FETCH;
                        retire          = 1'b1;
                    end
                    OP_JAL: begin
                        c.reg_write  = 1'b1;
                        c.mem_to_reg = M2R_PC;
                        c.pc_write   = 1'b1;
                        c.pc_source  = PC_ALUOUT;
                        next         = S_FETCH;
                        retire       = 1'b1;
                    end
                    OP_JALR: begin
                        c.reg_write  = 1'b1;
                        c.mem_to_reg = M2R_PC;
                        c.pc_write   = 1'b1;
                        c.alu_src_a  = A_RS1;
                        c.alu_src_b  = B_IMM;
                        next         = S_FETCH;
                        retire       = 1'b1;
                    end
`ifdef UPPER_IMM_EN
                    OP_LUI: begin
                        c.alu_src_a = A_ZERO;
                        c.alu_src_b = B_IMM;
                        next        = S_WB;
                    end
                    OP_AUIPC: begin
                        c.alu_src_b = B_IMM;
                        next        = S_WB;
                    end
`endif
                    default: begin
                        // opcode changed under us after decode: treat as illegal
                        next        = S_TRAP;
                        set_illegal = 1'b1;
                    end
                endcase
            end
            S_MEM: begin
                c.i_or_d    = 1'b1;
                c.mem_read  = is_load;
                c.mem_write = !is_load;
                if (mem_ready) begin
                    next   = is_load ? S_WB : S_FETCH;
                    retire = !is_load;
                end else if (timeout) begin
                    next          = S_TRAP;
                    set_bus_error = 1'b1;
                end
            end
            S_WB: begin
                c.reg_write  = 1'b1;
                c.mem_to_reg = is_load ? M2R_MDR : M2R_ALUOUT;
                next         = S_FETCH;
                retire       = 1'b1;
            end
            default: next = S_TRAP;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_FETCH;
            illegal   <= 1'b0;
            bus_error <= 1'b0;
            retired   <= '0;
        end else begin
            state     <= next;
            illegal   <= illegal | set_illegal;
            bus_error <= bus_error | set_bus_error;
            retired   <= retired + CNT_W'(retire);
        end
    end

    assign mem_read      = c.mem_read;
    assign mem_write     = c.mem_write;
    assign i_or_d        = c.i_or_d;
    assign ir_write      = c.ir_write;
    assign pc_write      = c.pc_write;
    assign pc_write_cond = c.pc_write_cond;
    assign pc_source     = c.pc_source;
    assign alu_src_a     = c.alu_src_a;
    assign alu_src_b     = c.alu_src_b;
    assign alu_op        = ALU_OP_W'(c.alu_op);
    assign mem_to_reg    = c.mem_to_reg;
    assign reg_write     = c.reg_write;

endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: directed self-checking bench for multicycle_control (MEM_TIMEOUT=4, CNT_W=4).
module tb_multicycle_control;

    localparam logic [2:0] FETCH = 3'd0, DECODE = 3'd1, EXEC = 3'd2, MEM = 3'd3, WB = 3'd4, TRAP = 3'd5;
    localparam logic [6:0] R = 7'b0110011, I = 7'b0010011, LD = 7'b0000011, ST = 7'b0100011;
    localparam logic [6:0] BR = 7'b1100011, JAL = 7'b1101111, JALR = 7'b1100111, LUI = 7'b0110111;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [6:0] opcode = 7'd0;
    logic       mem_ready = 1'b0;
    logic       mem_read, mem_write, i_or_d, ir_write, pc_write, pc_write_cond, reg_write;
    logic [1:0] pc_source, alu_src_a, alu_src_b, alu_op, mem_to_reg;
    logic [2:0] state;
    logic       illegal, bus_error;
    logic [3:0] retired;
    logic [16:0] ctl;

    int total = 0;
    int bad = 0;

    logic [16:0] f_rdy, f_wait, dec, ex_r, ex_i, ex_ls, ex_br, ex_jal, ex_jalr, ex_lui;
    logic [16:0] mem_ld, mem_st, wb_alu, wb_ld, zero;

    always #5 clk = ~clk;

    multicycle_control #(.ALU_OP_W(2), .MEM_TIMEOUT(4), .CNT_W(4)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
        .mem_read(mem_read), .mem_write(mem_write), .i_or_d(i_or_d), .ir_write(ir_write),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .pc_source(pc_source),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op), .mem_to_reg(mem_to_reg),
        .reg_write(reg_write), .state(state), .illegal(illegal), .bus_error(bus_error),
        .retired(retired)
    );

    assign ctl = {mem_read, mem_write, i_or_d, ir_write, pc_write, pc_write_cond,
                  pc_source, alu_src_a, alu_src_b, alu_op, mem_to_reg, reg_write};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [16:0] cv(input logic mr, mw, iod, irw, pcw, pcc,
                                       input logic [1:0] pcs, sa, sb, ao, m2r, input logic rw);
        return {mr, mw, iod, irw, pcw, pcc, pcs, sa, sb, ao, m2r, rw};
    endfunction

    // drive mem_ready, check state/controls for this cycle, advance one clock
    task automatic cyc(input logic rdy, input string tag, input logic [2:0] st, input logic [16:0] c);
        mem_ready = rdy;
        #1;
        check({tag, "/state"}, 32'(state), 32'(st));
        check({tag, "/ctl"}, 32'(ctl), 32'(c));
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        mem_ready = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        f_rdy   = cv(1, 0, 0, 1, 1, 0, 2'd0, 2'd0, 2'd1, 2'd0, 2'd0, 0);
        f_wait  = cv(1, 0, 0, 0, 0, 0, 2'd0, 2'd0, 2'd1, 2'd0, 2'd0, 0);
        dec     = cv(0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 2'd2, 2'd0, 2'd0, 0);
        ex_r    = cv(0, 0, 0, 0, 0, 0, 2'd0, 2'd1, 2'd0, 2'd2, 2'd0, 0);
        ex_i    = cv(0, 0, 0, 0, 0, 0, 2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 0);
        ex_ls   = cv(0, 0, 0, 0, 0, 0, 2'd0, 2'd1, 2'd2, 2'd0, 2'd0, 0);
        ex_br   = cv(0, 0, 0, 0, 0, 1, 2'd1, 2'd1, 2'd0, 2'd1, 2'd0, 0);
        ex_jal  = cv(0, 0, 0, 0, 1, 0, 2'd1, 2'd0, 2'd0, 2'd0, 2'd2, 1);
        ex_jalr = cv(0, 0, 0, 0, 1, 0, 2'd0, 2'd1, 2'd2, 2'd0, 2'd2, 1);
        ex_lui  = cv(0, 0, 0, 0, 0, 0, 2'd0, 2'd2, 2'd2, 2'd0, 2'd0, 0);
        mem_ld  = cv(1, 0, 1, 0, 0, 0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 0);
        mem_st  = cv(0, 1, 1, 0, 0, 0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 0);
        wb_alu  = cv(0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 1);
        wb_ld   = cv(0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 1);
        zero    = '0;

        do_reset();
        #1;
        check("rst/state", 32'(state), 32'(FETCH));
        check("rst/ctl", 32'(ctl), 32'(f_wait));
        check("rst/retired", 32'(retired), 0);
        check("rst/flags", {illegal, bus_error}, 0);

        // R-type, always ready
        opcode = R;
        cyc(1, "r/f", FETCH, f_rdy);
        cyc(1, "r/d", DECODE, dec);
        cyc(1, "r/x", EXEC, ex_r);
        check("r/ret_wb", 32'(retired), 0);
        cyc(1, "r/wb", WB, wb_alu);
        check("r/ret", 32'(retired), 1);

        // load with 3 wait cycles in MEM
        opcode = LD;
        cyc(1, "ld/f", FETCH, f_rdy);
        cyc(1, "ld/d", DECODE, dec);
        cyc(1, "ld/x", EXEC, ex_ls);
        for (int k = 0; k < 3; k++) cyc(0, "ld/mw", MEM, mem_ld);
        cyc(1, "ld/m", MEM, mem_ld);
        cyc(1, "ld/wb", WB, wb_ld);
        check("ld/ret", 32'(retired), 2);

        // store ready exactly at the timeout limit completes without a trap
        opcode = ST;
        cyc(1, "st/f", FETCH, f_rdy);
        cyc(1, "st/d", DECODE, dec);
        cyc(1, "st/x", EXEC, ex_ls);
        for (int k = 0; k < 4; k++) cyc(0, "st/mw", MEM, mem_st);
        cyc(1, "st/m", MEM, mem_st);
        check("st/state", 32'(state), 32'(FETCH));
        check("st/berr", 32'(bus_error), 0);
        check("st/ret", 32'(retired), 3);

        opcode = I;
        cyc(1, "i/f", FETCH, f_rdy);
        cyc(1, "i/d", DECODE, dec);
        cyc(1, "i/x", EXEC, ex_i);
        cyc(1, "i/wb", WB, wb_alu);
        opcode = JAL;
        cyc(1, "jal/f", FETCH, f_rdy);
        cyc(1, "jal/d", DECODE, dec);
        cyc(1, "jal/x", EXEC, ex_jal);
        opcode = JALR;
        cyc(1, "jalr/f", FETCH, f_rdy);
        cyc(1, "jalr/d", DECODE, dec);
        cyc(1, "jalr/x", EXEC, ex_jalr);
        check("jalr/ret", 32'(retired), 6);

        // illegal opcode traps from DECODE and stays until reset
        opcode = 7'd0;
        cyc(1, "ill/f", FETCH, f_rdy);
        cyc(1, "ill/d", DECODE, dec);
        check("ill/flag", 32'(illegal), 1);
        cyc(1, "ill/t0", TRAP, zero);
        cyc(1, "ill/t1", TRAP, zero);
        check("ill/ret", 32'(retired), 6);
        do_reset();
        #1;
        check("ill/rst_flag", 32'(illegal), 0);
        check("ill/rst_ret", 32'(retired), 0);

        opcode = LUI;
        cyc(1, "lui/f", FETCH, f_rdy);
        cyc(1, "lui/d", DECODE, dec);
`ifdef UPPER_IMM_EN
        cyc(1, "lui/x", EXEC, ex_lui);
        cyc(1, "lui/wb", WB, wb_alu);
        check("lui/flag", 32'(illegal), 0);
`else
        cyc(1, "lui/t", TRAP, zero);
        check("lui/flag", 32'(illegal), 1);
`endif

        // fetch timeout: 4 wait cycles tolerated, the stalled 5th traps
        do_reset();
        opcode = R;
        for (int k = 0; k < 5; k++) cyc(0, "to/f", FETCH, f_wait);
        check("to/berr", 32'(bus_error), 1);
        check("to/ill", 32'(illegal), 0);
        cyc(1, "to/t0", TRAP, zero);
        cyc(1, "to/t1", TRAP, zero);
        do_reset();
        #1;
        check("to/rst_state", 32'(state), 32'(FETCH));
        check("to/rst_berr", 32'(bus_error), 0);

        // reset during MEM of a store
        opcode = BR;
        cyc(1, "sr/bf", FETCH, f_rdy);
        cyc(1, "sr/bd", DECODE, dec);
        cyc(1, "sr/bx", EXEC, ex_br);
        check("sr/ret1", 32'(retired), 1);
        opcode = ST;
        cyc(1, "sr/f", FETCH, f_rdy);
        cyc(1, "sr/d", DECODE, dec);
        cyc(1, "sr/x", EXEC, ex_ls);
        cyc(0, "sr/m", MEM, mem_st);
        check("sr/mw_hi", 32'(mem_write), 1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        check("sr/mw_lo", 32'(mem_write), 0);
        check("sr/state", 32'(state), 32'(FETCH));
        check("sr/ret0", 32'(retired), 0);

        // 16 branches wrap the 4-bit retire counter
        do_reset();
        opcode = BR;
        for (int n = 0; n < 16; n++) begin
            cyc(1, "wr/f", FETCH, f_rdy);
            cyc(1, "wr/d", DECODE, dec);
            cyc(1, "wr/x", EXEC, ex_br);
            if (n == 14) check("wr/ret15", 32'(retired), 15);
        end
        check("wr/ret0", 32'(retired), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
